pipe_exec_ctrl: RTL and testbench

Execution controller for the 5-stage MIPS pipeline. It sequences the datapath on behalf of the debug unit. It accepts run, step and clear commands, drives the global pipeline-register enable and the PC enable, and detects the HALT instruction (opcode 6'b111111) at IF. After HALT it drains the in-flight instructions so they retire, then freezes. It sits between the debug unit command path and the enable inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_exec_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_exec_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exec_ctrl.sv
// pipe_exec_ctrl -- execution controller for the 5-stage MIPS pipeline.
//
// Sequences the datapath for the debug unit: accepts RUN / STEP / CLEAR
// commands, drives the global pipeline-register enable and the PC enable,
// detects HALT at IF, drains the in-flight instructions and then freezes.
//
// Optional feature macro: PIPE_EXEC_CTRL_STEP_EN
//   defined   : single-step (STEP command, o_state=2) is built.
//   undefined : STEP is accepted as a NOP in IDLE and DONE.
//
// Parameters
//   DRAIN_CYCLES  enabled cycles after the HALT fetch cycle (must be >= 1)
//   CNT_W         width of the executed-cycle counter
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_cmd_valid, i_cmd    command strobe / code (00 NOP, 01 RUN, 10 STEP, 11 CLEAR)
//   o_cmd_ready           command accepted on an edge with valid && ready
//   i_halt_fetched        IF stage holds HALT
//   o_pipe_en, o_pc_en    pipeline-register enable, PC update enable
//   o_pc_clr              one-cycle clear pulse for PC and pipeline registers
//   o_done                program finished, pipeline frozen
//   o_cycle_cnt           enabled cycles since last CLEAR/reset (saturating)
//   o_state               IDLE=0 RUN=1 STEP=2 DRAIN=3 DONE=4
module pipe_exec_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt_fetched,
  output logic             o_pipe_en,
  output logic             o_pc_en,
  output logic             o_pc_clr,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [2:0]       o_state
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
`ifdef PIPE_EXEC_CTRL_STEP_EN
  localparam logic [1:0] CMD_STEP  = 2'b10;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
`ifdef PIPE_EXEC_CTRL_STEP_EN
    , S_STEP = 3'd2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            halt_pending_q, halt_pending_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            pc_clr_q, clear_d;
  logic [CNT_W-1:0] cnt_q;

  // State and flag registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      halt_pending_q <= 1'b0;
      drain_q        <= '0;
      pc_clr_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      drain_q        <= drain_d;
      pc_clr_q       <= clear_d;
    end
  end

  // Next-state and flag update
  always_comb begin
    state_d        = state_q;
    halt_pending_d = halt_pending_q;
    drain_d        = drain_q;
    clear_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            // A halt left pending by single-stepping resumes as a drain.
            CMD_RUN:   state_d = halt_pending_q ? S_DRAIN : S_RUN;
`ifdef PIPE_EXEC_CTRL_STEP_EN
            CMD_STEP:  state_d = S_STEP;
`endif
            CMD_CLEAR: begin
              halt_pending_d = 1'b0;
              drain_d        = '0;
              clear_d        = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt_fetched) begin
          halt_pending_d = 1'b1;
          drain_d        = DW'(DRAIN_CYCLES);
          state_d        = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) state_d = S_DONE;
      end
`ifdef PIPE_EXEC_CTRL_STEP_EN
      S_STEP: begin
        state_d = S_IDLE;
        if (!halt_pending_q) begin
          if (i_halt_fetched) begin
            halt_pending_d = 1'b1;
            drain_d        = DW'(DRAIN_CYCLES);
          end
        end else begin
          drain_d = drain_q - DW'(1);
          if (drain_q == DW'(1)) state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (i_cmd_valid && (i_cmd == CMD_CLEAR)) begin
          halt_pending_d = 1'b0;
          drain_d        = '0;
          clear_d        = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    o_pipe_en   = 1'b0;
    o_cmd_ready = 1'b0;
    o_done      = 1'b0;
    unique case (state_q)
      S_IDLE:         o_cmd_ready = 1'b1;
      S_RUN, S_DRAIN: o_pipe_en   = 1'b1;
`ifdef PIPE_EXEC_CTRL_STEP_EN
      S_STEP:         o_pipe_en   = 1'b1;
`endif
      S_DONE: begin
        o_done      = 1'b1;
        o_cmd_ready = 1'b1;
      end
      default: ;
    endcase
    o_pc_en     = o_pipe_en && !halt_pending_q;
    o_pc_clr    = pc_clr_q;
    o_cycle_cnt = cnt_q;
    o_state     = state_q;
  end

  // Executed-cycle counter; CLEAR is only accepted while the pipe is idle,
  // so it never collides with an increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                      cnt_q <= '0;
    else if (clear_d)                 cnt_q <= '0;
    else if (o_pipe_en && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
module tb_pipe_exec_ctrl;

  localparam int unsigned D = 4;
  localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_CLR = 2'b11;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        o_cmd_ready;
  logic        halt;
  logic        o_pipe_en, o_pc_en, o_pc_clr, o_done;
  logic [31:0] o_cycle_cnt;
  logic [2:0]  o_state;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  // Reference model: counted cycles and single-step halt bookkeeping.
  int unsigned model_cnt  = 0;
  bit          model_hp   = 1'b0;
  int unsigned model_left = 0;

  pipe_exec_ctrl #(.DRAIN_CYCLES(D), .CNT_W(32)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .o_cmd_ready   (o_cmd_ready),
    .i_halt_fetched(halt),
    .o_pipe_en     (o_pipe_en),
    .o_pc_en       (o_pc_en),
    .o_pc_clr      (o_pc_clr),
    .o_done        (o_done),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd       = C_NOP;
  endtask

  // RUN with HALT presented on the h-th enabled cycle.
  task automatic run_prog(input int unsigned h);
    send_cmd(C_RUN);
    for (int unsigned j = 1; j <= h + D; j++) begin
      @(negedge clk);
      chk("run_pipe_en", {31'd0, o_pipe_en}, 32'd1);
      chk("run_pc_en", {31'd0, o_pc_en}, (j <= h) ? 32'd1 : 32'd0);
      chk("run_ready", {31'd0, o_cmd_ready}, 32'd0);
      model_cnt++;
      if (j == h) halt = 1'b1;
    end
    @(negedge clk);
    chk("run_done", {31'd0, o_done}, 32'd1);
    chk("run_end_pipe_en", {31'd0, o_pipe_en}, 32'd0);
    chk("run_end_state", {29'd0, o_state}, 32'd4);
    chk("run_cnt", o_cycle_cnt, model_cnt);
    halt = 1'b0;
  endtask

  task automatic do_clear();
    send_cmd(C_CLR);
    model_cnt  = 0;
    model_hp   = 1'b0;
    model_left = 0;
    @(negedge clk);
    chk("clr_pulse", {31'd0, o_pc_clr}, 32'd1);
    chk("clr_cnt", o_cycle_cnt, 32'd0);
    chk("clr_state", {29'd0, o_state}, 32'd0);
    @(negedge clk);
    chk("clr_pulse_end", {31'd0, o_pc_clr}, 32'd0);
  endtask

`ifdef PIPE_EXEC_CTRL_STEP_EN
  task automatic do_step(input bit h);
    send_cmd(C_STEP);
    @(negedge clk);
    chk("step_state", {29'd0, o_state}, 32'd2);
    chk("step_pipe_en", {31'd0, o_pipe_en}, 32'd1);
    chk("step_pc_en", {31'd0, o_pc_en}, model_hp ? 32'd0 : 32'd1);
    model_cnt++;
    halt = h;
    if (!model_hp && h) begin
      model_hp   = 1'b1;
      model_left = D;
    end else if (model_hp) begin
      model_left--;
    end
    @(negedge clk);
    halt = 1'b0;
    chk("step_after_pipe_en", {31'd0, o_pipe_en}, 32'd0);
    chk("step_after_state", {29'd0, o_state}, (model_hp && model_left == 0) ? 32'd4 : 32'd0);
    chk("step_after_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("step_cnt", o_cycle_cnt, model_cnt);
  endtask
`endif

  initial begin
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd       = C_NOP;
    halt        = 1'b0;
    #1;
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rst_pipe_en", {31'd0, o_pipe_en}, 32'd0);
    chk("rst_pc_en", {31'd0, o_pc_en}, 32'd0);
    chk("rst_pc_clr", {31'd0, o_pc_clr}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_cnt", o_cycle_cnt, 32'd0);
    #11 i_reset = 1'b0;
    @(negedge clk);

    // Directed program: HALT on the 10th enabled cycle -> 14 counted cycles.
    run_prog(10);
    chk("run10_cnt", o_cycle_cnt, 32'd14);

    // RUN and STEP are ignored in DONE.
    send_cmd(C_RUN);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_run_pipe_en", {31'd0, o_pipe_en}, 32'd0);
      chk("done_run_state", {29'd0, o_state}, 32'd4);
    end
    send_cmd(C_STEP);
    @(negedge clk);
    chk("done_step_pipe_en", {31'd0, o_pipe_en}, 32'd0);
    chk("done_step_cnt", o_cycle_cnt, 32'd14);
    do_clear();

`ifdef PIPE_EXEC_CTRL_STEP_EN
    for (int i = 0; i < 3; i++) do_step(1'b0);
    chk("step3_cnt", o_cycle_cnt, 32'd3);
    do_clear();
    for (int unsigned i = 1; i <= 9; i++) do_step(i == 5);
    chk("step9_done", {31'd0, o_done}, 32'd1);
    chk("step9_cnt", o_cycle_cnt, 32'd9);
    do_clear();
    begin
      int unsigned s;
      s = $urandom_range(1, 6);
      for (int unsigned i = 1; i <= s + D; i++) do_step(i == s);
      chk("rstep_done", {31'd0, o_done}, 32'd1);
      chk("rstep_cnt", o_cycle_cnt, s + D);
    end
    do_clear();
`else
    send_cmd(C_STEP);
    @(negedge clk);
    chk("nostep_pipe_en", {31'd0, o_pipe_en}, 32'd0);
    chk("nostep_state", {29'd0, o_state}, 32'd0);
    chk("nostep_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("nostep_cnt", o_cycle_cnt, 32'd0);
`endif

    // Randomized programs.
    for (int k = 0; k < 3; k++) begin
      int unsigned h;
      h = $urandom_range(1, 15);
      run_prog(h);
      chk("rrun_cnt", o_cycle_cnt, h + D);
      do_clear();
    end

    // Reset in the 2nd drain cycle.
    send_cmd(C_RUN);
    for (int unsigned j = 1; j <= 3 + 2; j++) begin
      @(negedge clk);
      if (j == 3) halt = 1'b1;
    end
    i_reset = 1'b1;
    #1;
    chk("mid_rst_state", {29'd0, o_state}, 32'd0);
    chk("mid_rst_pipe_en", {31'd0, o_pipe_en}, 32'd0);
    chk("mid_rst_pc_en", {31'd0, o_pc_en}, 32'd0);
    chk("mid_rst_done", {31'd0, o_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("mid_rst_cnt", o_cycle_cnt, 32'd0);
    #1;
    i_reset   = 1'b0;
    halt      = 1'b0;
    model_cnt = 0;
    model_hp  = 1'b0;
    run_prog(5);
    chk("post_rst_cnt", o_cycle_cnt, 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
